// File: rtl/core_pkg.sv
// Shared core datapath defaults and the forwarding-source record.
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;
    localparam int unsigned CORE_RAW  = 5;

    typedef struct packed {
        logic                 valid;
        logic [CORE_RAW-1:0]  rd;
        logic                 reg_write;
        logic                 data_valid;
        logic [CORE_XLEN-1:0] data;
    } fwd_src_t;

endpackage

// File: rtl/core_ex_fwd_sel.sv
// Per-operand forwarding priority select: EM register, then sources 0..NSRC-1, then RF.
module core_ex_fwd_sel
    import core_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN,
    parameter int unsigned NSRC = 2,
    parameter int unsigned RAW  = CORE_RAW
) (
    input  logic [RAW-1:0]       rs,
    input  logic [XLEN-1:0]      rf_value,
    input  logic                 em_valid,
    input  logic                 em_reg_write,
    input  logic [RAW-1:0]       em_rd,
    input  logic [XLEN-1:0]      em_result,
    input  logic [NSRC-1:0]      fwd_valid,
    input  logic [NSRC*RAW-1:0]  fwd_rd,
    input  logic [NSRC-1:0]      fwd_reg_write,
    input  logic [NSRC-1:0]      fwd_data_valid,
    input  logic [NSRC*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]      value,
    output logic                 hazard
);

    logic found;

    always_comb begin
        value  = rf_value;
        hazard = 1'b0;
        found  = 1'b0;
        if (rs == '0) begin
            value = '0;
        end else begin
            if (em_valid && em_reg_write && em_rd == rs) begin
                value = em_result;
                found = 1'b1;
            end
            // First match ends the search; a pending load there blocks older sources.
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (!found && fwd_valid[i] && fwd_reg_write[i] &&
                    fwd_rd[i*RAW +: RAW] == rs) begin
                    found = 1'b1;
                    value = fwd_data[i*XLEN +: XLEN];
                    if (!fwd_data_valid[i])
                        hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_ex_fwd_stage.sv
// EX stage operand forwarding, hazard stall and EX/MEM pipeline register.
module core_ex_fwd_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN,
    parameter int unsigned NSRC = 2,
    parameter int unsigned RAW  = CORE_RAW
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 de_valid,
    output logic                 de_ready,
    input  logic [RAW-1:0]       de_rs1,
    input  logic [RAW-1:0]       de_rs2,
    input  logic                 de_rs1_valid,
    input  logic                 de_rs2_valid,
    input  logic [XLEN-1:0]      de_rs1_value,
    input  logic [XLEN-1:0]      de_rs2_value,
    input  logic [RAW-1:0]       de_rd,
    input  logic                 de_reg_write,
    input  logic [XLEN-1:0]      de_result,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    input  logic [NSRC-1:0]      fwd_valid,
    input  logic [NSRC*RAW-1:0]  fwd_rd,
    input  logic [NSRC-1:0]      fwd_reg_write,
    input  logic [NSRC-1:0]      fwd_data_valid,
    input  logic [NSRC*XLEN-1:0] fwd_data,
    input  logic                 flush_en,
    output logic                 em_valid,
    output logic                 em_start_handle,
    input  logic                 em_ready,
    output logic [RAW-1:0]       em_rd,
    output logic                 em_reg_write,
    output logic [XLEN-1:0]      em_result,
    output logic [31:0]          stall_cnt
);

    logic hazard_rs1;
    logic hazard_rs2;
    logic hazard;
    logic adv;
    logic accept;

    core_ex_fwd_sel #(.XLEN(XLEN), .NSRC(NSRC), .RAW(RAW)) u_sel_rs1 (
        .rs             (de_rs1),
        .rf_value       (de_rs1_value),
        .em_valid       (em_valid),
        .em_reg_write   (em_reg_write),
        .em_rd          (em_rd),
        .em_result      (em_result),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_reg_write  (fwd_reg_write),
        .fwd_data_valid (fwd_data_valid),
        .fwd_data       (fwd_data),
        .value          (rs1_value),
        .hazard         (hazard_rs1)
    );

    core_ex_fwd_sel #(.XLEN(XLEN), .NSRC(NSRC), .RAW(RAW)) u_sel_rs2 (
        .rs             (de_rs2),
        .rf_value       (de_rs2_value),
        .em_valid       (em_valid),
        .em_reg_write   (em_reg_write),
        .em_rd          (em_rd),
        .em_result      (em_result),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_reg_write  (fwd_reg_write),
        .fwd_data_valid (fwd_data_valid),
        .fwd_data       (fwd_data),
        .value          (rs2_value),
        .hazard         (hazard_rs2)
    );

    always_comb begin
        hazard   = (de_rs1_valid && hazard_rs1) || (de_rs2_valid && hazard_rs2);
        adv      = !em_valid || em_ready;
        de_ready = adv && !hazard && !flush_en;
        accept   = de_ready && de_valid;
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            em_valid        <= 1'b0;
            em_start_handle <= 1'b0;
            em_rd           <= '0;
            em_reg_write    <= 1'b0;
            em_result       <= '0;
            stall_cnt       <= '0;
        end else begin
            // Payload follows adv alone; only em_valid is qualified by accept.
            if (adv) begin
                em_valid     <= accept;
                em_rd        <= de_rd;
                em_reg_write <= de_reg_write;
                em_result    <= de_result;
            end else if (flush_en) begin
                em_valid <= 1'b0;
            end
            em_start_handle <= accept;
            if (de_valid && hazard && !flush_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_core_ex_fwd_stage.sv
// Directed bench for core_ex_fwd_stage with an EM-result scoreboard queue.
module tb_core_ex_fwd_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NSRC = 2;
    localparam int unsigned RAW  = 5;

    typedef struct {
        logic [RAW-1:0]  rd;
        logic            reg_write;
        logic [XLEN-1:0] result;
    } em_exp_t;

    logic                 clk = 1'b0;
    logic                 rest;
    logic                 de_valid;
    logic                 de_ready;
    logic [RAW-1:0]       de_rs1, de_rs2;
    logic                 de_rs1_valid, de_rs2_valid;
    logic [XLEN-1:0]      de_rs1_value, de_rs2_value;
    logic [RAW-1:0]       de_rd;
    logic                 de_reg_write;
    logic [XLEN-1:0]      de_result;
    logic [XLEN-1:0]      rs1_value, rs2_value;
    logic [NSRC-1:0]      fwd_valid, fwd_reg_write, fwd_data_valid;
    logic [NSRC*RAW-1:0]  fwd_rd;
    logic [NSRC*XLEN-1:0] fwd_data;
    logic                 flush_en;
    logic                 em_valid, em_start_handle, em_ready;
    logic [RAW-1:0]       em_rd;
    logic                 em_reg_write;
    logic [XLEN-1:0]      em_result;
    logic [31:0]          stall_cnt;

    int      n_chk  = 0;
    int      n_fail = 0;
    em_exp_t sb[$];

    always #5 clk = ~clk;

    core_ex_fwd_stage #(.XLEN(XLEN), .NSRC(NSRC), .RAW(RAW)) dut (
        .clk             (clk),
        .rest            (rest),
        .de_valid        (de_valid),
        .de_ready        (de_ready),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_rs1_valid    (de_rs1_valid),
        .de_rs2_valid    (de_rs2_valid),
        .de_rs1_value    (de_rs1_value),
        .de_rs2_value    (de_rs2_value),
        .de_rd           (de_rd),
        .de_reg_write    (de_reg_write),
        .de_result       (de_result),
        .rs1_value       (rs1_value),
        .rs2_value       (rs2_value),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_reg_write   (fwd_reg_write),
        .fwd_data_valid  (fwd_data_valid),
        .fwd_data        (fwd_data),
        .flush_en        (flush_en),
        .em_valid        (em_valid),
        .em_start_handle (em_start_handle),
        .em_ready        (em_ready),
        .em_rd           (em_rd),
        .em_reg_write    (em_reg_write),
        .em_result       (em_result),
        .stall_cnt       (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int unsigned i, input logic v, input logic [RAW-1:0] rd,
                           input logic dv, input logic [XLEN-1:0] data);
        fwd_valid[i]              = v;
        fwd_reg_write[i]          = v;
        fwd_rd[i*RAW +: RAW]      = rd;
        fwd_data_valid[i]         = dv;
        fwd_data[i*XLEN +: XLEN]  = data;
    endtask

    task automatic set_instr(input logic v, input logic [RAW-1:0] rd, input logic [XLEN-1:0] res);
        de_valid     = v;
        de_rd        = rd;
        de_reg_write = 1'b1;
        de_result    = res;
    endtask

    task automatic push_exp(input logic [RAW-1:0] rd, input logic [XLEN-1:0] res);
        em_exp_t e;
        e.rd        = rd;
        e.reg_write = 1'b1;
        e.result    = res;
        sb.push_back(e);
    endtask

    // Called right after an edge at which the bench expects EM to have been loaded.
    task automatic pop_chk(input string tag);
        em_exp_t e;
        chk({tag, "_start"}, 32'(em_start_handle), 32'd1);
        chk({tag, "_valid"}, 32'(em_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rd"}, 32'(em_rd), 32'(e.rd));
            chk({tag, "_rw"}, 32'(em_reg_write), 32'(e.reg_write));
            chk({tag, "_res"}, em_result, e.result);
        end
    endtask

    initial begin
        rest = 1'b1; de_valid = 1'b0; de_rs1 = '0; de_rs2 = '0;
        de_rs1_valid = 1'b0; de_rs2_valid = 1'b0; de_rs1_value = '0; de_rs2_value = '0;
        de_rd = '0; de_reg_write = 1'b0; de_result = '0;
        fwd_valid = '0; fwd_rd = '0; fwd_reg_write = '0; fwd_data_valid = '0; fwd_data = '0;
        flush_en = 1'b0; em_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_em_valid", 32'(em_valid), 32'd0);
        chk("rst_start", 32'(em_start_handle), 32'd0);
        chk("rst_em_rd", 32'(em_rd), 32'd0);
        chk("rst_em_result", em_result, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        rest = 1'b0;

        // EM holds rd5=0x11, fwd0 also offers rd5=0x22: EM wins
        set_instr(1'b1, 5'd5, 32'h11);
        #1 chk("load0_ready", 32'(de_ready), 32'd1);
        push_exp(5'd5, 32'h11);
        tick();
        pop_chk("load0");
        de_valid = 1'b0; em_ready = 1'b0;
        de_rs1 = 5'd5; de_rs1_valid = 1'b1; de_rs1_value = 32'h999;
        set_src(0, 1'b1, 5'd5, 1'b1, 32'h22);
        #1;
        chk("em_prio_rs1", rs1_value, 32'h11);
        chk("em_stall_ready", 32'(de_ready), 32'd0);

        // EM empties: fwd0 wins; rs2 falls through to RF
        em_ready = 1'b1;
        tick();
        chk("drain_valid", 32'(em_valid), 32'd0);
        chk("drain_start", 32'(em_start_handle), 32'd0);
        de_rs2 = 5'd9; de_rs2_value = 32'hABC;
        #1;
        chk("fwd0_rs1", rs1_value, 32'h22);
        chk("rf_rs2", rs2_value, 32'hABC);

        // x0 never forwards and never hazards
        de_rs1 = 5'd0; de_rs1_value = 32'h1234;
        set_src(0, 1'b1, 5'd0, 1'b0, 32'hFF);
        #1;
        chk("x0_value", rs1_value, 32'd0);
        chk("x0_ready", 32'(de_ready), 32'd1);

        // Pending load at fwd0 blocks older fwd1 for 3 cycles
        de_rs1_valid = 1'b0; de_rs2 = 5'd0;
        set_src(0, 1'b1, 5'd7, 1'b0, 32'h0);
        set_src(1, 1'b1, 5'd7, 1'b1, 32'h33);
        de_rs2 = 5'd7; de_rs2_valid = 1'b1;
        set_instr(1'b1, 5'd3, 32'h77);
        for (int i = 0; i < 3; i++) begin
            #1 chk("haz_ready", 32'(de_ready), 32'd0);
            tick();
            chk("haz_em_valid", 32'(em_valid), 32'd0);
            chk("haz_start", 32'(em_start_handle), 32'd0);
        end
        chk("haz_stall3", stall_cnt, 32'd3);

        // Load data arrives: accepted, single start pulse
        set_src(0, 1'b1, 5'd7, 1'b1, 32'h44);
        #1;
        chk("rel_ready", 32'(de_ready), 32'd1);
        chk("rel_rs2", rs2_value, 32'h44);
        push_exp(5'd3, 32'h77);
        tick();
        pop_chk("rel");
        de_valid = 1'b0;
        tick();
        chk("rel_start_once", 32'(em_start_handle), 32'd0);
        chk("rel_stall_hold", stall_cnt, 32'd3);

        // Back-to-back dependent chain through EM forwarding
        fwd_valid = '0; fwd_reg_write = '0; de_rs2_valid = 1'b0;
        de_rs1_valid = 1'b1; de_rs1_value = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 5'(10 + i), 32'(32'hA0 + i));
            de_rs1 = (i == 0) ? 5'd0 : 5'(9 + i);
            #1;
            chk("b2b_ready", 32'(de_ready), 32'd1);
            chk("b2b_rs1", rs1_value, (i == 0) ? 32'd0 : 32'(32'hA0 + i - 1));
            push_exp(5'(10 + i), 32'(32'hA0 + i));
            tick();
            pop_chk("b2b");
        end

        // Back-pressure holds EM with a new instruction waiting
        em_ready = 1'b0; de_rs1_valid = 1'b0;
        set_instr(1'b1, 5'd20, 32'hBB);
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_ready", 32'(de_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(em_valid), 32'd1);
            chk("bp_start", 32'(em_start_handle), 32'd0);
            chk("bp_rd", 32'(em_rd), 32'd12);
            chk("bp_res", em_result, 32'hA2);
        end

        // Flush while back-pressured
        flush_en = 1'b1;
        #1 chk("flush_ready", 32'(de_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(em_valid), 32'd0);
        chk("flush_start", 32'(em_start_handle), 32'd0);

        // Flush together with hazard: no count
        em_ready = 1'b1;
        set_src(0, 1'b1, 5'd7, 1'b0, 32'h0);
        de_rs2 = 5'd7; de_rs2_valid = 1'b1;
        tick();
        chk("flushhaz_stall", stall_cnt, 32'd3);
        chk("flushhaz_valid", 32'(em_valid), 32'd0);
        flush_en = 1'b0; de_valid = 1'b0;

        // Counter saturation from a preloaded value
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt;
        #1 chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
        de_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_stall", stall_cnt, 32'hFFFF_FFFF);
        end

        // Reset mid-stream discards loaded EM
        fwd_valid = '0; fwd_reg_write = '0; de_rs2_valid = 1'b0;
        set_instr(1'b1, 5'd9, 32'h55);
        push_exp(5'd9, 32'h55);
        tick();
        pop_chk("pre_rst");
        rest = 1'b1; de_valid = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(em_valid), 32'd0);
        chk("mid_rst_start", 32'(em_start_handle), 32'd0);
        chk("mid_rst_rd", 32'(em_rd), 32'd0);
        chk("mid_rst_rw", 32'(em_reg_write), 32'd0);
        chk("mid_rst_res", em_result, 32'd0);
        chk("mid_rst_stall", stall_cnt, 32'd0);
        de_rs1 = 5'd9; de_rs1_valid = 1'b1; de_rs1_value = 32'h321;
        #1 chk("rst_comb_rs1", rs1_value, 32'h321);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
